// File: rtl/qdec_ctx_save.sv
// CABAC context-model snapshot engine: saves all context entries into a backup store and restores them.
// Optional QDEC_CTX_SAVE_CHECKSUM_EN: save_checksum accumulates captured entries (otherwise tied to 0).
module qdec_ctx_save #(
    parameter int CTX_NUM = 566,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 7,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              save_start,
    input  logic              restore_start,
    output logic              ctx_rd_en,
    output logic [ADDR_W-1:0] ctx_rd_addr,
    input  logic [DATA_W-1:0] ctx_rd_data,
    output logic              ctx_wr_en,
    output logic [ADDR_W-1:0] ctx_wr_addr,
    output logic [DATA_W-1:0] ctx_wr_data,
    output logic              busy,
    output logic              save_valid,
    output logic              save_done_intr,
    output logic              restore_done_intr,
    output logic [15:0]       save_checksum
);
    typedef enum logic [2:0] {
        IDLE,
        SAVE_RD,
        SAVE_DRAIN,
        RESTORE_RD,
        RESTORE_WR,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CTX_NUM - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    state_t            state;
    logic [ADDR_W-1:0] rs_idx;
    logic [1:0]        drain_cnt;
    logic [RD_LAT-1:0] cap_vld;
    logic [ADDR_W-1:0] cap_addr [RD_LAT];
    logic              capture;
    logic              save_go;
    logic              restore_go;
    logic [DATA_W-1:0] backup [CTX_NUM];

    assign save_go    = (state == IDLE) && save_start;
    assign restore_go = (state == IDLE) && !save_start && restore_start && save_valid;
    assign capture    = rst_n && cap_vld[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            rs_idx            <= '0;
            drain_cnt         <= '0;
            ctx_rd_en         <= 1'b0;
            ctx_rd_addr       <= '0;
            ctx_wr_en         <= 1'b0;
            ctx_wr_addr       <= '0;
            ctx_wr_data       <= '0;
            busy              <= 1'b0;
            save_valid        <= 1'b0;
            save_done_intr    <= 1'b0;
            restore_done_intr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (save_go) begin
                        state       <= SAVE_RD;
                        busy        <= 1'b1;
                        ctx_rd_en   <= 1'b1;
                        ctx_rd_addr <= '0;
                        save_valid  <= 1'b0;
                    end else if (restore_go) begin
                        state  <= RESTORE_RD;
                        busy   <= 1'b1;
                        rs_idx <= '0;
                    end
                end
                SAVE_RD: begin
                    // Address holds at the last entry rather than wrapping.
                    if (ctx_rd_addr == LAST_ADDR) begin
                        ctx_rd_en <= 1'b0;
                        drain_cnt <= '0;
                        state     <= SAVE_DRAIN;
                    end else begin
                        ctx_rd_addr <= ctx_rd_addr + ADDR_W'(1);
                    end
                end
                SAVE_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state          <= DONE;
                        save_done_intr <= 1'b1;
                        save_valid     <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                RESTORE_RD: begin
                    ctx_wr_en   <= 1'b1;
                    ctx_wr_addr <= rs_idx;
                    ctx_wr_data <= backup[rs_idx];
                    rs_idx      <= rs_idx + ADDR_W'(1);
                    state       <= RESTORE_WR;
                end
                RESTORE_WR: begin
                    if (ctx_wr_addr == LAST_ADDR) begin
                        ctx_wr_en         <= 1'b0;
                        restore_done_intr <= 1'b1;
                        state             <= DONE;
                    end else begin
                        ctx_wr_addr <= rs_idx;
                        ctx_wr_data <= backup[rs_idx];
                        rs_idx      <= (rs_idx == LAST_ADDR) ? rs_idx : rs_idx + ADDR_W'(1);
                    end
                end
                DONE: begin
                    save_done_intr    <= 1'b0;
                    restore_done_intr <= 1'b0;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay line pairing each read strobe with its address until the data returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) cap_addr[i] <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                cap_vld[i]  <= cap_vld[i-1];
                cap_addr[i] <= cap_addr[i-1];
            end
            cap_vld[0]  <= ctx_rd_en;
            cap_addr[0] <= ctx_rd_addr;
        end
    end

    // NOTE: the backup store has no reset; save_valid alone says whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (capture) backup[cap_addr[RD_LAT-1]] <= ctx_rd_data;
    end

`ifdef QDEC_CTX_SAVE_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            save_checksum <= '0;
        end else if (save_go) begin
            save_checksum <= '0;
        end else if (capture) begin
            save_checksum <= save_checksum + 16'(ctx_rd_data);
        end
    end
`else
    assign save_checksum = '0;
`endif

endmodule

// File: tb/tb_qdec_ctx_save.sv
// Self-checking bench for qdec_ctx_save: one instance at read latency 1 and one at latency 3,
// each beside a behavioural context memory; a snapshot model predicts reads, writes and checksums.
module tb_qdec_ctx_save;
    localparam int N  = 566;
    localparam int AW = 10;
    localparam int DW = 7;

`ifdef QDEC_CTX_SAVE_CHECKSUM_EN
    localparam logic [15:0] CONST_CSUM = 16'h8B4A;
`else
    localparam logic [15:0] CONST_CSUM = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          save_start [2];
    logic          restore_start [2];
    logic          rd_en [2];
    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rd_data [2];
    logic          wr_en [2];
    logic [AW-1:0] wr_addr [2];
    logic [DW-1:0] wr_data [2];
    logic          busy [2];
    logic          save_valid [2];
    logic          sdone [2];
    logic          rdone [2];
    logic [15:0]   csum [2];

    qdec_ctx_save #(.CTX_NUM(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .save_start(save_start[0]), .restore_start(restore_start[0]),
        .ctx_rd_en(rd_en[0]), .ctx_rd_addr(rd_addr[0]), .ctx_rd_data(rd_data[0]),
        .ctx_wr_en(wr_en[0]), .ctx_wr_addr(wr_addr[0]), .ctx_wr_data(wr_data[0]),
        .busy(busy[0]), .save_valid(save_valid[0]), .save_done_intr(sdone[0]),
        .restore_done_intr(rdone[0]), .save_checksum(csum[0])
    );

    qdec_ctx_save #(.CTX_NUM(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .save_start(save_start[1]), .restore_start(restore_start[1]),
        .ctx_rd_en(rd_en[1]), .ctx_rd_addr(rd_addr[1]), .ctx_rd_data(rd_data[1]),
        .ctx_wr_en(wr_en[1]), .ctx_wr_addr(wr_addr[1]), .ctx_wr_data(wr_data[1]),
        .busy(busy[1]), .save_valid(save_valid[1]), .save_done_intr(sdone[1]),
        .restore_done_intr(rdone[1]), .save_checksum(csum[1])
    );

    // Context memories: mode 0 = all 63, 1 = k^0x55, 2 = zero, 3 = random pattern
    logic [DW-1:0] mem [2][N];
    logic [DW-1:0] rnd_pat [N];
    logic          fill_en [2];
    int            fill_mode [2];
    logic [DW-1:0] lat1_q;
    logic [DW-1:0] lat3_q [3];

    function automatic logic [DW-1:0] pat(input int mode, input int k);
        case (mode)
            0:       return 7'd63;
            1:       return 7'(k) ^ 7'h55;
            2:       return 7'd0;
            default: return rnd_pat[k];
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fill_en[i]) begin
                for (int k = 0; k < N; k++) mem[i][k] <= pat(fill_mode[i], k);
            end else if (wr_en[i]) begin
                mem[i][wr_addr[i]] <= wr_data[i];
            end
        end
        lat1_q    <= rd_en[0] ? mem[0][rd_addr[0]] : 7'h7F;
        lat3_q[0] <= rd_en[1] ? mem[1][rd_addr[1]] : 7'h7F;
        lat3_q[1] <= lat3_q[0];
        lat3_q[2] <= lat3_q[1];
    end
    assign rd_data[0] = lat1_q;
    assign rd_data[1] = lat3_q[2];

    // Reference: what each memory holds and what the last completed snapshot holds
    logic [DW-1:0] env_model [2][N];
    logic [DW-1:0] bk [2][N];

    int checks = 0;
    int errors = 0;

    // Trace observed over one operation
    int rd_cnt, rd_first, rd_bad, wr_cnt, wr_first, wr_bad_addr, wr_bad_data, conflicts;
    int busy_first, busy_last, sdone_cnt, sdone_cyc, rdone_cnt, rdone_cyc, sv_first;
    logic busy_entry, zero_after_rst;
    logic [15:0] cs_at_done, cs_end;

    function automatic logic outputs_zero(input int i);
        return ({rd_en[i], rd_addr[i], wr_en[i], wr_addr[i], wr_data[i], busy[i],
                 save_valid[i], sdone[i], rdone[i], csum[i]} === '0);
    endfunction

    function automatic logic [15:0] model_csum(input int i);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(bk[i][k]);
`ifdef QDEC_CTX_SAVE_CHECKSUM_EN
        return 16'(s);
`else
        return 16'(s & 0);
`endif
    endfunction

    // Caller sits at a negedge; the start is sampled on the next edge (edge 0).
    task automatic run_op(input int i, input bit sv, input bit rs, input int fmode,
                          input int ncyc, input int inj_cyc, input int rst_cyc);
        rd_cnt = 0; rd_first = 0; rd_bad = 0; wr_cnt = 0; wr_first = 0;
        wr_bad_addr = 0; wr_bad_data = 0; conflicts = 0; busy_first = 0; busy_last = 0;
        sdone_cnt = 0; sdone_cyc = 0; rdone_cnt = 0; rdone_cyc = 0; sv_first = 0;
        zero_after_rst = 1'b0; cs_at_done = '0; cs_end = '0;
        busy_entry = busy[i];
        save_start[i] = sv;
        restore_start[i] = rs;
        if (fmode >= 0) begin
            fill_en[i] = 1'b1;
            fill_mode[i] = fmode;
        end
        @(negedge clk);
        save_start[i] = 1'b0;
        restore_start[i] = 1'b0;
        fill_en[i] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (rd_en[i] === 1'b1) begin
                if (rd_cnt == 0) rd_first = c;
                if (rd_addr[i] !== AW'(rd_cnt)) rd_bad++;
                rd_cnt++;
            end
            if (wr_en[i] === 1'b1) begin
                if (wr_cnt == 0) wr_first = c;
                if (wr_cnt < N) begin
                    if (wr_addr[i] !== AW'(wr_cnt)) wr_bad_addr++;
                    if (wr_data[i] !== bk[i][wr_cnt]) wr_bad_data++;
                end
                wr_cnt++;
            end
            if (rd_en[i] === 1'b1 && wr_en[i] === 1'b1) conflicts++;
            if (sdone[i] === 1'b1) begin
                if (sdone_cnt == 0) sdone_cyc = c;
                sdone_cnt++;
                cs_at_done = csum[i];
            end
            if (rdone[i] === 1'b1) begin
                if (rdone_cnt == 0) rdone_cyc = c;
                rdone_cnt++;
            end
            if (busy[i] === 1'b1) begin
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (save_valid[i] === 1'b1 && sv_first == 0) sv_first = c;
            if (c == rst_cyc + 1) zero_after_rst = outputs_zero(i);
            cs_end = csum[i];
            save_start[i] = (c == inj_cyc);
            restore_start[i] = (c == inj_cyc);
            rst_n = (c == rst_cyc) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        save_start[i] = 1'b0;
        restore_start[i] = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (!outputs_zero(i)) begin
                errors++;
                $display("FAIL reset_hold inst%0d outputs not all zero (busy=%b sv=%b rd_en=%b)",
                         i, busy[i], save_valid[i], rd_en[i]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (!outputs_zero(i)) begin
                errors++;
                $display("FAIL reset_idle inst%0d outputs not all zero after release", i);
            end
        end
    endtask

    task automatic test_restore_invalid(input int i, input string tag);
        run_op(i, 1'b0, 1'b1, -1, 20, 0, -5);
        checks++;
        if (wr_cnt !== 0) begin errors++; $display("FAIL %s writes got %0d exp 0", tag, wr_cnt); end
        checks++;
        if (rdone_cnt !== 0) begin errors++; $display("FAIL %s restore_pulses got %0d exp 0", tag, rdone_cnt); end
        checks++;
        if (busy_first !== 0) begin errors++; $display("FAIL %s busy_seen got cycle %0d exp never", tag, busy_first); end
    endtask

    task automatic test_save(input int i, input int lat, input int fmode, input bit with_restore,
                             input int inj_cyc, input int tail, input string tag);
        int exp_done;
        logic [15:0] exp_cs;
        exp_done = N + lat + 1;
        if (fmode == 3) for (int k = 0; k < N; k++) rnd_pat[k] = 7'($urandom);
        for (int k = 0; k < N; k++) env_model[i][k] = pat(fmode, k);
        run_op(i, 1'b1, with_restore, fmode, exp_done + tail, inj_cyc, -5);
        for (int k = 0; k < N; k++) bk[i][k] = env_model[i][k];
        exp_cs = model_csum(i);
        checks++;
        if (rd_cnt !== N) begin errors++; $display("FAIL %s read_count got %0d exp %0d", tag, rd_cnt, N); end
        checks++;
        if (rd_bad !== 0) begin errors++; $display("FAIL %s read_order bad=%0d exp 0", tag, rd_bad); end
        checks++;
        if (rd_first !== 1) begin errors++; $display("FAIL %s first_read got cycle %0d exp 1", tag, rd_first); end
        checks++;
        if (wr_cnt !== 0 || rdone_cnt !== 0) begin
            errors++; $display("FAIL %s stray_restore writes=%0d pulses=%0d exp 0/0", tag, wr_cnt, rdone_cnt);
        end
        checks++;
        if (sdone_cnt !== 1 || sdone_cyc !== exp_done) begin
            errors++; $display("FAIL %s save_done got %0d pulses first@%0d exp 1@%0d", tag, sdone_cnt, sdone_cyc, exp_done);
        end
        checks++;
        if (busy_first !== 1 || busy_last !== exp_done) begin
            errors++; $display("FAIL %s busy_window got %0d..%0d exp 1..%0d", tag, busy_first, busy_last, exp_done);
        end
        checks++;
        if (sv_first !== exp_done) begin errors++; $display("FAIL %s save_valid_rise got %0d exp %0d", tag, sv_first, exp_done); end
        checks++;
        if (cs_at_done !== exp_cs) begin errors++; $display("FAIL %s checksum got %h exp %h", tag, cs_at_done, exp_cs); end
        checks++;
        if (cs_end !== exp_cs) begin errors++; $display("FAIL %s checksum_hold got %h exp %h", tag, cs_end, exp_cs); end
        checks++;
        if (conflicts !== 0) begin errors++; $display("FAIL %s rd_wr_overlap got %0d exp 0", tag, conflicts); end
    endtask

    task automatic test_restore(input int i, input int fmode, input string tag);
        int mem_bad = 0;
        if (fmode == 3) for (int k = 0; k < N; k++) rnd_pat[k] = 7'($urandom);
        run_op(i, 1'b0, 1'b1, fmode, N + 4, 0, -5);
        for (int k = 0; k < N; k++) env_model[i][k] = bk[i][k];
        for (int k = 0; k < N; k++) if (mem[i][k] !== env_model[i][k]) mem_bad++;
        checks++;
        if (busy_entry !== 1'b0) begin errors++; $display("FAIL %s busy_at_start got %b exp 0", tag, busy_entry); end
        checks++;
        if (wr_cnt !== N) begin errors++; $display("FAIL %s write_count got %0d exp %0d", tag, wr_cnt, N); end
        checks++;
        if (wr_first !== 2) begin errors++; $display("FAIL %s first_write got cycle %0d exp 2", tag, wr_first); end
        checks++;
        if (wr_bad_addr !== 0 || wr_bad_data !== 0) begin
            errors++; $display("FAIL %s write_stream bad_addr=%0d bad_data=%0d exp 0/0", tag, wr_bad_addr, wr_bad_data);
        end
        checks++;
        if (rdone_cnt !== 1 || rdone_cyc !== N + 2) begin
            errors++; $display("FAIL %s restore_done got %0d pulses first@%0d exp 1@%0d", tag, rdone_cnt, rdone_cyc, N + 2);
        end
        checks++;
        if (busy_last !== N + 2) begin errors++; $display("FAIL %s busy_last got %0d exp %0d", tag, busy_last, N + 2); end
        checks++;
        if (rd_cnt !== 0 || sdone_cnt !== 0) begin
            errors++; $display("FAIL %s stray_save reads=%0d pulses=%0d exp 0/0", tag, rd_cnt, sdone_cnt);
        end
        checks++;
        if (mem_bad !== 0) begin errors++; $display("FAIL %s memory_contents mismatched=%0d exp 0", tag, mem_bad); end
        checks++;
        if (save_valid[i] !== 1'b1) begin errors++; $display("FAIL %s save_valid_kept got %b exp 1", tag, save_valid[i]); end
    endtask

    task automatic test_save_const();
        test_save(0, 1, 0, 1'b0, 0, 2, "save_const");
        checks++;
        if (cs_at_done !== CONST_CSUM) begin
            errors++; $display("FAIL save_const_literal checksum got %h exp %h", cs_at_done, CONST_CSUM);
        end
    endtask

    task automatic test_simultaneous_then_restore();
        test_save(0, 1, 1, 1'b1, 0, 2, "save_with_restore_req");
        test_restore(0, 2, "restore_xor55");
    endtask

    task automatic test_ignored_starts();
        test_save(0, 1, 3, 1'b0, int'($urandom_range(560, 2)), 2, "save_ignored_starts");
        test_restore(0, 2, "restore_random");
    endtask

    task automatic test_back_to_back();
        test_save(0, 1, 3, 1'b0, 0, 0, "save_b2b");
        test_restore(0, 2, "restore_b2b");
        test_restore(0, 2, "restore_repeat");
    endtask

    task automatic test_reset_mid_save();
        rnd_pat[0] = 7'($urandom);
        run_op(0, 1'b1, 1'b0, 3, 305, 0, 300);
        checks++;
        if (zero_after_rst !== 1'b1) begin errors++; $display("FAIL mid_reset outputs_after_reset not all zero"); end
        checks++;
        if (rd_cnt !== 300) begin errors++; $display("FAIL mid_reset read_count got %0d exp 300", rd_cnt); end
        checks++;
        if (sdone_cnt !== 0 || save_valid[0] !== 1'b0) begin
            errors++; $display("FAIL mid_reset completion pulses=%0d save_valid=%b exp 0/0", sdone_cnt, save_valid[0]);
        end
        test_restore_invalid(0, "restore_after_reset");
    endtask

    task automatic test_rdlat3();
        test_save(1, 3, 3, 1'b0, 0, 2, "save_lat3");
        test_restore(1, 2, "restore_lat3");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            save_start[i] = 1'b0;
            restore_start[i] = 1'b0;
            fill_en[i] = 1'b0;
            fill_mode[i] = 0;
        end
        test_reset();
        test_restore_invalid(0, "restore_no_snapshot");
        test_save_const();
        test_simultaneous_then_restore();
        test_ignored_starts();
        test_back_to_back();
        test_reset_mid_save();
        test_rdlat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
